// File: rtl/rap_adder_seq_if.sv
// rtl/rap_adder_seq_if.sv - operand/result handshake bundle for rap_adder_seq
interface rap_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             approx_flag;
  logic             corrected;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, approx_flag, corrected
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, approx_flag, corrected
  );
endinterface

// File: rtl/rap_adder_seq.sv
// rtl/rap_adder_seq.sv - window-limited-carry approximate adder with segment-serial exact repair
module rap_adder_seq #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rap_adder_seq_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hazard_cnt
);
  localparam int NSEG  = (WIDTH + WINDOW - 1) / WINDOW;
  localparam int PAD_W = NSEG * WINDOW;
  localparam int SUM_W = PAD_W + 1;
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, CORR, OUT} state_t;

  state_t           state, state_nxt;
  logic [PAD_W-1:0] a_r, b_r;
  logic             mode_r;
  logic [SEG_W-1:0] seg;
  logic             carry;
  logic [SUM_W-1:0] sum_r;
  logic             approx_r, corr_r;

  logic [WIDTH-1:0] p, g, c;
  logic [WIDTH:0]   approx_sum;
  logic             hazard;
  logic             term, run;
  logic [WINDOW:0]  seg_sum;
  int               seg_off;
  logic             last_seg;

  always_comb begin
    p    = a_r[WIDTH-1:0] ^ b_r[WIDTH-1:0];
    g    = a_r[WIDTH-1:0] & b_r[WIDTH-1:0];
    c    = '0;
    term = 1'b0;
    run  = 1'b0;
    // c[i]: any generate within the last WINDOW positions that propagates up to i
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (j <= i && j + WINDOW > i) begin
          term = g[j];
          for (int k = 0; k < WIDTH; k++) begin
            if (k > j && k <= i) term = term & p[k];
          end
          c[i] = c[i] | term;
        end
      end
    end
    hazard = 1'b0;
    for (int j = 1; j <= WIDTH - WINDOW; j++) begin
      run = 1'b1;
      for (int k = 0; k < WINDOW; k++) run = run & p[j+k];
      hazard = hazard | run;
    end
    approx_sum[0] = p[0];
    for (int i = 1; i < WIDTH; i++) approx_sum[i] = p[i] ^ c[i-1];
    approx_sum[WIDTH] = c[WIDTH-1];
  end

  // Padding bits are zero, so a short last segment leaves its carry at bit WIDTH.
  always_comb begin
    seg_off  = int'(seg) * WINDOW;
    seg_sum  = {1'b0, a_r[seg_off +: WINDOW]} + {1'b0, b_r[seg_off +: WINDOW]}
             + {{WINDOW{1'b0}}, carry};
    last_seg = (seg == SEG_W'(NSEG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = EVAL;
      EVAL: state_nxt = (mode_r && hazard) ? CORR : OUT;
      CORR: if (last_seg) state_nxt = OUT;
      OUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == IDLE);
    bus.out_valid   = (state == OUT);
    bus.sum         = sum_r[WIDTH:0];
    bus.approx_flag = approx_r;
    bus.corrected   = corr_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= 1'b0;
      seg      <= '0;
      carry    <= 1'b0;
      sum_r    <= '0;
      approx_r <= 1'b0;
      corr_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r    <= PAD_W'(bus.a);
          b_r    <= PAD_W'(bus.b);
          mode_r <= bus.mode;
        end
        EVAL: if (mode_r && hazard) begin
          seg   <= '0;
          carry <= 1'b0;
        end else begin
          sum_r    <= SUM_W'(approx_sum);
          approx_r <= hazard & ~mode_r;
          corr_r   <= 1'b0;
        end
        CORR: begin
          sum_r[seg_off +: WINDOW+1] <= seg_sum;
          carry <= seg_sum[WINDOW];
          if (last_seg) begin
            seg      <= '0;
            corr_r   <= 1'b1;
            approx_r <= 1'b0;
          end else begin
            seg <= seg + SEG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hazard_cnt <= '0;
    else if (cnt_clr)
      hazard_cnt <= '0;
    else if (state == EVAL && hazard && hazard_cnt != '1)
      hazard_cnt <= hazard_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_rap_adder_seq.sv
// tb/tb_rap_adder_seq.sv - directed table-driven bench for rap_adder_seq
module tb_rap_adder_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] hazard_cnt;
  logic [1:0]  hazard_cnt2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rap_adder_seq_if #(.WIDTH(16)) bus ();
  rap_adder_seq_if #(.WIDTH(16)) bus2 ();

  // Second instance runs in lockstep with a 2-bit counter to observe saturation.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.a         = bus.a;
  assign bus2.b         = bus.b;
  assign bus2.mode      = bus.mode;
  assign bus2.out_ready = bus.out_ready;

  rap_adder_seq #(.WIDTH(16), .WINDOW(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .hazard_cnt(hazard_cnt)
  );
  rap_adder_seq #(.WIDTH(16), .WINDOW(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clr(cnt_clr), .hazard_cnt(hazard_cnt2)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [16:0] sum;
    logic        af;
    logic        corr;
    int          lat;
    int          hz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                        output int lat);
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.mode = tm; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mode = ~tm; bus.a = ~ta; bus.b = ~tb_;
    chk("busy_after_accept", {31'd0, bus.in_ready}, 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_after_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
  endtask

  initial begin
    int lat;
    logic [15:0] cnt0;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0, 1'b0, 2, 0};
    vecs[1] = '{16'h01FF, 16'h0001, 1'b0, 17'h00000, 1'b1, 1'b0, 2, 1};
    vecs[2] = '{16'h01FF, 16'h0001, 1'b1, 17'h00200, 1'b0, 1'b1, 4, 1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 17'h0FE00, 1'b1, 1'b0, 2, 1};
    vecs[4] = '{16'h01FE, 16'h0000, 1'b1, 17'h001FE, 1'b0, 1'b1, 4, 1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0, 1'b0, 2, 0};
    vecs[6] = '{16'h1234, 16'h4321, 1'b1, 17'h05555, 1'b0, 1'b0, 2, 0};
    vecs[7] = '{16'hFFFF, 16'h0001, 1'b1, 17'h10000, 1'b0, 1'b1, 4, 1};

    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
    chk("reset_sum", {15'd0, bus.sum}, 32'h0);
    chk("reset_flags", {30'd0, bus.approx_flag, bus.corrected}, 32'h0);
    chk("reset_cnt", {16'd0, hazard_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cnt0 = hazard_cnt;
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_sum", i), {15'd0, bus.sum}, {15'd0, vecs[i].sum});
      chk($sformatf("v%0d_approx_flag", i), {31'd0, bus.approx_flag}, {31'd0, vecs[i].af});
      chk($sformatf("v%0d_corrected", i), {31'd0, bus.corrected}, {31'd0, vecs[i].corr});
      chk($sformatf("v%0d_hazard_cnt", i), {16'd0, hazard_cnt}, 32'(cnt0) + 32'(vecs[i].hz));
      finish_op();
    end
    chk("cnt_after_table", {16'd0, hazard_cnt}, 32'd5);
    chk("cnt2_saturated", {30'd0, hazard_cnt2}, 32'd3);

    // Backpressure: result held, new requests ignored.
    run_op(16'h01FF, 16'h0001, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = 16'h0003; bus.b = 16'h0004;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_state", i), {30'd0, bus.in_ready, bus.out_valid}, 32'h1);
      chk($sformatf("hold%0d_sum", i), {15'd0, bus.sum}, 32'h0);
      chk($sformatf("hold%0d_flag", i), {31'd0, bus.approx_flag}, 32'h1);
    end
    bus.in_valid = 1'b0;
    finish_op();
    chk("cnt_after_hold", {16'd0, hazard_cnt}, 32'd6);

    // cnt_clr in the same cycle as a hazard increment.
    @(negedge clk);
    bus.a = 16'h01FF; bus.b = 16'h0001; bus.mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_vs_inc_valid", {31'd0, bus.out_valid}, 32'h1);
    chk("clr_vs_inc_cnt", {16'd0, hazard_cnt}, 32'h0);
    chk("clr_vs_inc_cnt2", {30'd0, hazard_cnt2}, 32'h0);
    finish_op();
    run_op(16'h01FF, 16'h0001, 1'b0, lat);
    chk("cnt_after_clr_inc", {16'd0, hazard_cnt}, 32'd1);
    finish_op();

    // Reset asserted mid-correction.
    @(negedge clk);
    bus.a = 16'h01FF; bus.b = 16'h0001; bus.mode = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("corr_in_progress", {30'd0, bus.in_ready, bus.out_valid}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_corr_state", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
    chk("rst_corr_sum", {15'd0, bus.sum}, 32'h0);
    chk("rst_corr_flags", {30'd0, bus.approx_flag, bus.corrected}, 32'h0);
    chk("rst_corr_cnt", {16'd0, hazard_cnt}, 32'h0);
    @(posedge clk); #1;
    chk("rst_corr_no_result", {31'd0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    chk("post_reset_latency", lat, 32'd2);
    chk("post_reset_sum", {15'd0, bus.sum}, 32'h100);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
